taylor_stage_ctrl: RTL and testbench
====================================

// Module: taylor_stage_ctrl
// PURPOSE
//  Sequencer driving the control side of one Taylor stage (mul_ss, add_ss, mul_ss_en, add_ss_en).
//  Accepts an operand pair (IN_A = x-a, IN_B = seed coefficient) by valid/ready handshake.
//  Runs N_ITER multiply/add Horner steps; stage result is 1 + A*(1 + A*(... (1 + A*B))).
//  Captures the result and returns it by valid/ready; one operation in flight at a time.
//  Fixed-point format is 3.23: [25:23] integer, [22:0] fraction; 1.0 = 26'h0800000.
// PARAMETERS
//  N_ITER  4   number of MUL+ADD pairs per operation (>=1); counter width = clog2(N_ITER)
//  W       26  datapath width (3 integer + 23 fraction bits)
// PORTS
//  CLK        in   1  clock, rising edge
//  RST_N      in   1  synchronous reset, active-low
//  IN_VALID   in   1  operand pair valid
//  IN_READY   out  1  block can accept an operand pair (high only in IDLE)
//  IN_A       in   W  multiplicand x-a, captured on accept
//  IN_B       in   W  seed coefficient, captured on accept
//  OUT_VALID  out  1  result valid (high only in DONE)
//  OUT_READY  in   1  downstream accepts result
//  OUT        out  W  registered result
//  STAGE_A    out  W  captured IN_A, drives stage IN_A
//  STAGE_B    out  W  captured IN_B, drives stage IN_B
//  STAGE_OUT  in   W  stage combinational OUT (reg_mul + 1)
//  mul_ss     out  1  stage mul port select: 1 = IN_B (first step), 0 = reg_add
//  add_ss     out  1  mirrors add_ss_en (reserved select, stage ignores it)
//  mul_ss_en  out  1  stage loads reg_mul this edge
//  add_ss_en  out  1  stage loads reg_add this edge
// BEHAVIOUR
//  Reset (RST_N=0 at edge): state=IDLE, iter=0; IN_READY=1 after reset.
//  Reset also clears OUT_VALID, mul_ss, add_ss, mul_ss_en, add_ss_en, OUT, STAGE_A and STAGE_B to 0.
//  States: IDLE, MUL, ADD, DONE. All control outputs are decoded from registered state and iter only.
//  Control outputs never depend combinationally on inputs.
//  IDLE: IN_READY=1. On IN_VALID: capture IN_A->STAGE_A and IN_B->STAGE_B, set iter=0, go to MUL.
//  MUL: mul_ss_en=1, mul_ss=(iter==0), add_ss_en=0. Next state is ADD.
//  ADD: add_ss_en=add_ss=1, mul_ss_en=0.
//   - If iter==N_ITER-1: OUT<=STAGE_OUT, go to DONE.
//   - Otherwise: iter<=iter+1, go to MUL.
//  DONE: OUT_VALID=1 and OUT is held stable. On OUT_READY, go to IDLE.
//   - No same-cycle re-accept: IN_READY stays 0 in DONE.
//  mul_ss_en and add_ss_en are never both 1. All stage enables are 0 in IDLE and DONE.
//  Latency: accept at edge T gives OUT_VALID=1 after edge T+2*N_ITER, so throughput is 1 op per 2*N_ITER+2 cycles.
//  IN_VALID in MUL, ADD or DONE is ignored (not accepted); IN_A and IN_B may change freely there.
//  OUT_READY outside DONE is ignored.
//  RST_N low mid-operation (any state): abandon the operation and return to IDLE next edge; no OUT_VALID pulse.
//  Stage reg_mul and reg_add are not cleared; the next operation starts with mul_ss=1, so stale values are irrelevant.
//  Arithmetic overflow beyond 3 integer bits is the stage's concern; the controller passes STAGE_OUT unmodified.
// CONFIGURATION
//  TAYLOR_CTRL_ABORT_EN defined: adds input ABORT (1 bit).
//   - ABORT=1 at an edge in MUL or ADD forces IDLE; OUT and OUT_VALID stay unchanged (0).
//   - ABORT is ignored in IDLE and DONE.
//   - RST_N has priority over ABORT.
//  TAYLOR_CTRL_ABORT_EN undefined: no ABORT port; operations always run to DONE.
// TESTING (stage instantiated with real multiplier/adder)
//  Basic: N_ITER=2, A=26'h0400000 (0.5), B=26'h0800000 (1.0) -> OUT=26'h0E00000 (1.75), OUT_VALID at T+4.
//  Zero operand: N_ITER=4, A=0, B=26'h0800000 -> OUT=26'h0800000 (1.0); enable trace is M,A,M,A,M,A,M,A with mul_ss=1 only on the first M.
//  Backpressure: hold OUT_READY=0 for 10 cycles in DONE -> OUT stable, IN_READY=0, new IN_VALID not accepted; release -> IDLE next cycle.
//  Back-to-back: IN_VALID held high with two operand pairs, OUT_READY=1 -> both results correct, second accepted 2*N_ITER+2 cycles after first.
//  Reset mid-op: RST_N=0 during the second ADD -> IDLE next edge, OUT_VALID never asserts, next op computes correctly.
//  ABORT (macro on): ABORT=1 in MUL with iter=1 -> IDLE next edge, OUT unchanged, IN_READY=1; ABORT in DONE has no effect.

Source files
------------

// File: rtl/taylor_stage_ctrl.sv
// Sequencer for one Taylor stage: accepts (x-a, seed), runs N_ITER
// Horner MUL/ADD steps through the stage, returns 1 + A*(...(1 + A*B)).
//
// Ports:
//   CLK, RST_N (sync, active-low)
//   IN_VALID/IN_READY, IN_A, IN_B      operand handshake
//   OUT_VALID/OUT_READY, OUT           result handshake
//   STAGE_A, STAGE_B, STAGE_OUT        stage datapath connections
//   mul_ss, add_ss, mul_ss_en, add_ss_en  stage controls
// Config: define TAYLOR_CTRL_ABORT_EN to add the ABORT input, which
// drops an operation in MUL or ADD back to IDLE.

module taylor_stage_ctrl #(
  parameter int N_ITER = 4,
  parameter int W      = 26
) (
  input  logic         CLK,
  input  logic         RST_N,
`ifdef TAYLOR_CTRL_ABORT_EN
  input  logic         ABORT,
`endif
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] IN_A,
  input  logic [W-1:0] IN_B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT,
  output logic [W-1:0] STAGE_A,
  output logic [W-1:0] STAGE_B,
  input  logic [W-1:0] STAGE_OUT,
  output logic         mul_ss,
  output logic         add_ss,
  output logic         mul_ss_en,
  output logic         add_ss_en
);

  // Keep at least one counter bit so N_ITER=1 still elaborates.
  localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [IW-1:0] ILAST = IW'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] iter;
  logic          accept;
  logic          iter_inc;
  logic          out_load;
  logic          abort_req;

`ifdef TAYLOR_CTRL_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    iter_inc  = 1'b0;
    out_load  = 1'b0;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    mul_ss    = 1'b0;
    mul_ss_en = 1'b0;
    add_ss    = 1'b0;
    add_ss_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          accept   = 1'b1;
          state_nx = S_MUL;
        end
      end
      S_MUL: begin
        mul_ss_en = 1'b1;
        // First step multiplies by the seed; later steps by reg_add.
        mul_ss    = (iter == '0);
        state_nx  = abort_req ? S_IDLE : S_ADD;
      end
      S_ADD: begin
        add_ss_en = 1'b1;
        add_ss    = 1'b1;
        if (abort_req) begin
          state_nx = S_IDLE;
        end else if (iter == ILAST) begin
          out_load = 1'b1;
          state_nx = S_DONE;
        end else begin
          iter_inc = 1'b1;
          state_nx = S_MUL;
        end
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      iter    <= '0;
      OUT     <= '0;
      STAGE_A <= '0;
      STAGE_B <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        STAGE_A <= IN_A;
        STAGE_B <= IN_B;
        iter    <= '0;
      end
      if (iter_inc) iter <= iter + 1'b1;
      if (out_load) OUT <= STAGE_OUT;
    end
  end

endmodule

// File: tb/tb_taylor_stage_ctrl.sv
// Directed bench for taylor_stage_ctrl with a behavioural Taylor stage
// (fixed-point 3.23 multiplier plus +1.0 adder) closing the loop.

module tb_taylor_stage_ctrl;

  localparam int N = 4;
  localparam int W = 26;
  localparam logic [W-1:0] ONE = 26'h0800000;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] IN_A = '0;
  logic [W-1:0] IN_B = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] OUT;
  logic [W-1:0] STAGE_A;
  logic [W-1:0] STAGE_B;
  logic [W-1:0] STAGE_OUT;
  logic         mul_ss;
  logic         add_ss;
  logic         mul_ss_en;
  logic         add_ss_en;
`ifdef TAYLOR_CTRL_ABORT_EN
  logic         ABORT = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  taylor_stage_ctrl #(.N_ITER(N), .W(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
`ifdef TAYLOR_CTRL_ABORT_EN
    .ABORT     (ABORT),
`endif
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .STAGE_A   (STAGE_A),
    .STAGE_B   (STAGE_B),
    .STAGE_OUT (STAGE_OUT),
    .mul_ss    (mul_ss),
    .add_ss    (add_ss),
    .mul_ss_en (mul_ss_en),
    .add_ss_en (add_ss_en)
  );

  // Stage model
  logic [W-1:0]   reg_mul = '0;
  logic [W-1:0]   reg_add = '0;
  logic [W-1:0]   mul_src;
  logic [2*W-1:0] prod;
  assign mul_src   = mul_ss ? STAGE_B : reg_add;
  assign prod      = {{W{1'b0}}, STAGE_A} * {{W{1'b0}}, mul_src};
  assign STAGE_OUT = reg_mul + ONE;
  always @(posedge CLK) begin
    if (mul_ss_en) reg_mul <= prod[W+22:23];
    if (add_ss_en) reg_add <= STAGE_OUT;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accept one pair, wait for OUT_VALID, return result and latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    IN_A = a;
    IN_B = b;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    lat = 0;
    while (!OUT_VALID && lat < 50) begin
      tick();
      lat++;
    end
    res = OUT;
  endtask

  task automatic release_out();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", IN_READY);
    end
    checks++;
    if ({OUT_VALID, mul_ss, add_ss, mul_ss_en, add_ss_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {OUT_VALID, mul_ss, add_ss, mul_ss_en, add_ss_en});
    end
    checks++;
    if ({OUT, STAGE_A, STAGE_B} !== '0) begin
      failures++;
      $display("FAIL reset_data out=%h a=%h b=%h exp=0", OUT, STAGE_A, STAGE_B);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] r;
    int lat;
    // A=0.5,B=1.0, 4 steps: 1.9375
    run_op(26'h0400000, ONE, r, lat);
    checks++;
    if (lat !== 2 * N) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, 2 * N);
    end
    checks++;
    if (r !== 26'h0F80000) begin
      failures++;
      $display("FAIL basic_out got=%h exp=0f80000", r);
    end
    checks++;
    if (STAGE_A !== 26'h0400000 || STAGE_B !== ONE) begin
      failures++;
      $display("FAIL basic_stage_ab a=%h b=%h exp=0400000/0800000",
               STAGE_A, STAGE_B);
    end
    release_out();
    // A=0.25,B=0.5: 681/512
    run_op(26'h0200000, 26'h0400000, r, lat);
    checks++;
    if (r !== 26'h0AA4000) begin
      failures++;
      $display("FAIL quarter_out got=%h exp=0aa4000", r);
    end
    release_out();
  endtask

  task automatic test_zero_trace();
    logic [2:0] got;
    logic [2:0] exp;
    int bad;
    bad = 0;
    IN_A = '0;
    IN_B = ONE;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      got = {mul_ss_en, add_ss_en, mul_ss};
      exp = (k % 2 == 0) ? {2'b10, (k == 0)} : 3'b010;
      if (got !== exp || add_ss !== add_ss_en) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL zero_trace bad_cycles got=%0d exp=0", bad);
    end
    checks++;
    if (OUT_VALID !== 1'b1 || OUT !== ONE) begin
      failures++;
      $display("FAIL zero_out valid=%b out=%h exp=1/0800000", OUT_VALID, OUT);
    end
    checks++;
    if (mul_ss_en | add_ss_en) begin
      failures++;
      $display("FAIL done_enables got=%b%b exp=00", mul_ss_en, add_ss_en);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r;
    int lat;
    int bad;
    run_op(26'h0400000, ONE, r, lat);
    IN_VALID = 1'b1;
    IN_A = 26'h0123456;
    IN_B = 26'h0654321;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (OUT !== 26'h0F80000 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0 ||
          STAGE_A !== 26'h0400000)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_hold bad_cycles got=%0d exp=0", bad);
    end
    IN_VALID = 1'b0;
    release_out();
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release rdy=%b vld=%b exp=1/0",
               IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int t_acc[2];
    logic [W-1:0] res[2];
    int n_acc;
    int n_res;
    n_acc = 0;
    n_res = 0;
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    IN_A = 26'h0400000;
    IN_B = ONE;
    for (t = 0; t < 40 && n_res < 2; t++) begin
      if (IN_READY && n_acc < 2) begin
        t_acc[n_acc] = t;
        n_acc++;
      end
      if (OUT_VALID) begin
        res[n_res] = OUT;
        n_res++;
      end
      tick();
      if (n_acc == 1) begin
        IN_A = 26'h0200000;
        IN_B = 26'h0400000;
      end
      if (n_acc == 2) IN_VALID = 1'b0;
    end
    OUT_READY = 1'b0;
    IN_VALID = 1'b0;
    checks++;
    if (n_res !== 2 || n_acc !== 2) begin
      failures++;
      $display("FAIL b2b_count acc=%0d res=%0d exp=2/2", n_acc, n_res);
    end else begin
      checks++;
      if (t_acc[1] - t_acc[0] !== 2 * N + 2) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d exp=%0d",
                 t_acc[1] - t_acc[0], 2 * N + 2);
      end
      checks++;
      if (res[0] !== 26'h0F80000 || res[1] !== 26'h0AA4000) begin
        failures++;
        $display("FAIL b2b_results got=%h,%h exp=0f80000,0aa4000",
                 res[0], res[1]);
      end
    end
    tick();
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] r;
    int lat;
    int seen;
    IN_A = 26'h0400000;
    IN_B = ONE;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (add_ss_en !== 1'b1 || mul_ss_en !== 1'b0) begin
      failures++;
      $display("FAIL midop_in_add got=%b%b exp=01", mul_ss_en, add_ss_en);
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checks++;
    if (IN_READY !== 1'b1 || OUT !== '0) begin
      failures++;
      $display("FAIL midop_idle rdy=%b out=%h exp=1/0", IN_READY, OUT);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (OUT_VALID) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midop_no_valid got=%0d exp=0", seen);
    end
    run_op(26'h0200000, 26'h0400000, r, lat);
    checks++;
    if (r !== 26'h0AA4000 || lat !== 2 * N) begin
      failures++;
      $display("FAIL midop_next_op out=%h lat=%0d exp=0aa4000/%0d",
               r, lat, 2 * N);
    end
    release_out();
  endtask

`ifdef TAYLOR_CTRL_ABORT_EN
  task automatic test_abort();
    logic [W-1:0] r;
    logic [W-1:0] prev;
    int lat;
    prev = OUT;
    IN_A = 26'h0400000;
    IN_B = ONE;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if (IN_READY !== 1'b1 || OUT !== prev || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL abort_mul rdy=%b out=%h vld=%b exp=1/%h/0",
               IN_READY, OUT, OUT_VALID, prev);
    end
    run_op(26'h0400000, ONE, r, lat);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || OUT !== 26'h0F80000) begin
      failures++;
      $display("FAIL abort_done vld=%b out=%h exp=1/0f80000", OUT_VALID, OUT);
    end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_trace();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef TAYLOR_CTRL_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
